// File: rtl/data_memory_lsu.sv
// Byte-addressable data memory with sized loads/stores, sign/zero extension and fault reporting.
// Optional macro DMEM_WRITE_FORWARD_EN: a simultaneous read+write returns write-first data.
module data_memory_lsu #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [1:0]            memSize,
    input  logic                  memUnsigned,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  readValid,
    output logic                  accessFault,
    output logic [ADDR_WIDTH-1:0] faultAddr
);
    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int OFF_W    = $clog2(BYTES);
    localparam int IDX_W    = $clog2(DEPTH_WORDS);
    localparam int MAX_SIZE = OFF_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [OFF_W-1:0]      offset;
    logic [IDX_W-1:0]      word_idx;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  size_ok, align_ok, range_ok, legal, fault;
    logic [BYTES-1:0]      byte_en;
    logic [DATA_WIDTH-1:0] wdata_lane, rd_word, rd_shift;
    int                    off_i, nbytes_i;

    logic [DATA_WIDTH-1:0] read_data_d, read_data_q;
    logic                  read_valid_d, read_valid_q;
    logic                  access_fault_d, access_fault_q;
    logic [ADDR_WIDTH-1:0] fault_addr_d, fault_addr_q;

    // Keep the low accessed bytes, then sign- or zero-extend to the full width.
    function automatic logic [DATA_WIDTH-1:0] extend_load(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [1:0]            size,
        input logic                  is_unsigned
    );
        int                           sh;
        logic signed [DATA_WIDTH-1:0] aligned;
        logic signed [DATA_WIDTH-1:0] sext;
        logic [DATA_WIDTH-1:0]        zext;
        sh = DATA_WIDTH - (8 << size);
        if (sh < 0) sh = 0;
        aligned = $signed(raw << sh);
        sext    = aligned >>> sh;
        zext    = (raw << sh) >> sh;
        if (is_unsigned) return zext;
        return sext;
    endfunction

    always_comb begin
        offset    = address[OFF_W-1:0];
        word_addr = address >> OFF_W;
        word_idx  = address[OFF_W +: IDX_W];
        off_i     = int'(offset);
        nbytes_i  = 1 << memSize;
        size_ok   = (int'(memSize) <= MAX_SIZE);
        align_ok  = ((off_i & (nbytes_i - 1)) == 0);
        // Range is judged on the whole address so out-of-range accesses never alias low words.
        range_ok  = (word_addr < ADDR_WIDTH'(DEPTH_WORDS));
        legal     = size_ok && align_ok && range_ok;
        fault     = (memRead || memWrite) && !legal;

        byte_en = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (b >= off_i && b < off_i + nbytes_i) byte_en[b] = 1'b1;
        end
        wdata_lane = writeData << (8 * off_i);

        rd_word = mem[word_idx];
`ifdef DMEM_WRITE_FORWARD_EN
        if (memWrite && legal) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) rd_word[b*8 +: 8] = wdata_lane[b*8 +: 8];
            end
        end
`endif
        rd_shift = rd_word >> (8 * off_i);
    end

    always_comb begin
        read_data_d    = read_data_q;
        if (memRead) read_data_d = legal ? extend_load(rd_shift, memSize, memUnsigned) : '0;
        read_valid_d   = memRead;
        access_fault_d = fault;
        fault_addr_d   = fault ? address : fault_addr_q;
    end

    // Response stage: one-cycle load latency, fault pulse and sticky fault address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q    <= '0;
            read_valid_q   <= 1'b0;
            access_fault_q <= 1'b0;
            fault_addr_q   <= '0;
        end else begin
            read_data_q    <= read_data_d;
            read_valid_q   <= read_valid_d;
            access_fault_q <= access_fault_d;
            fault_addr_q   <= fault_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (memWrite && legal) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byte_en[b]) mem[word_idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
            end
        end
    end

    assign readData    = read_data_q;
    assign readValid   = read_valid_q;
    assign accessFault = access_fault_q;
    assign faultAddr   = fault_addr_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: directed table, reset corner case and randomized ops vs a byte-array model.
module tb_data_memory_lsu;
    logic        clk;
    logic        reset;
    logic        memRead, memWrite, memUnsigned;
    logic [1:0]  memSize;
    logic [31:0] address, writeData;
    logic [31:0] readData, faultAddr;
    logic        readValid, accessFault;

    data_memory_lsu dut (
        .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .memSize(memSize), .memUnsigned(memUnsigned), .address(address),
        .writeData(writeData), .readData(readData), .readValid(readValid),
        .accessFault(accessFault), .faultAddr(faultAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          ev;
        bit          ef;
        logic [31:0] ed;
        logic [31:0] efa;
    } vec_t;

    int          n_vec;
    int          n_err;
    logic [7:0]  mref [0:4095];
    logic [31:0] m_hold;
    logic [31:0] m_fa;
    vec_t        tab [20];

`ifdef DMEM_WRITE_FORWARD_EN
    localparam logic [31:0] SIMUL_EXP = 32'h0000_1234;
`else
    localparam logic [31:0] SIMUL_EXP = 32'hFFFF_BEEF;
`endif

    function automatic vec_t mk(bit rd, bit wr, logic [1:0] sz, bit uns, logic [31:0] addr,
                                logic [31:0] wd, bit ev, bit ef, logic [31:0] ed, logic [31:0] efa);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
        v.ev = ev; v.ef = ef; v.ed = ed; v.efa = efa;
        return v;
    endfunction

    function automatic bit m_legal(logic [1:0] sz, logic [31:0] addr);
        int nb;
        nb = 1 << sz;
        return (sz != 2'd3) && ((addr % nb) == 0) && (addr < 32'h1000);
    endfunction

    function automatic logic [31:0] m_load(logic [1:0] sz, bit uns, logic [31:0] addr);
        logic [63:0] v;
        int nb;
        int a;
        nb = 1 << sz;
        a  = int'(addr[11:0]);
        v  = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mref[a + i];
        if (!uns && v[8*nb-1]) begin
            for (int j = 8*nb; j < 64; j++) v[j] = 1'b1;
        end
        return v[31:0];
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        int nb;
        int a;
        nb = 1 << sz;
        a  = int'(addr[11:0]);
        for (int i = 0; i < nb; i++) mref[a + i] = wd[8*i +: 8];
    endtask

    task automatic predict(input vec_t vi, output vec_t vo);
        bit legal;
        vo    = vi;
        legal = m_legal(vi.sz, vi.addr);
        if ((vi.rd || vi.wr) && !legal) m_fa = vi.addr;
`ifdef DMEM_WRITE_FORWARD_EN
        if (vi.wr && legal) m_store(vi.sz, vi.addr, vi.wd);
        if (vi.rd) m_hold = legal ? m_load(vi.sz, vi.uns, vi.addr) : 32'h0;
`else
        if (vi.rd) m_hold = legal ? m_load(vi.sz, vi.uns, vi.addr) : 32'h0;
        if (vi.wr && legal) m_store(vi.sz, vi.addr, vi.wd);
`endif
        vo.ev  = vi.rd;
        vo.ef  = (vi.rd || vi.wr) && !legal;
        vo.ed  = m_hold;
        vo.efa = m_fa;
    endtask

    task automatic chk(input string ph, input int idx, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] %s: got %h, expected %h", ph, idx, field, act, exp);
        end
    endtask

    task automatic step(input string ph, input int idx, input vec_t v);
        memRead     = v.rd;
        memWrite    = v.wr;
        memSize     = v.sz;
        memUnsigned = v.uns;
        address     = v.addr;
        writeData   = v.wd;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        chk(ph, idx, "readValid",   32'(readValid),   32'(v.ev));
        chk(ph, idx, "accessFault", 32'(accessFault), 32'(v.ef));
        chk(ph, idx, "readData",    readData,         v.ed);
        chk(ph, idx, "faultAddr",   faultAddr,        v.efa);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vec_t e;
        int   sel;

        //            rd wr sz uns addr           wd             ev ef exp data        exp faultAddr
        tab[0]  = mk(0, 1, 2, 0, 32'h10,       32'hDEADBEEF, 0, 0, 32'h0,        32'h0);
        tab[1]  = mk(1, 0, 2, 0, 32'h10,       32'h0,        1, 0, 32'hDEADBEEF, 32'h0);
        tab[2]  = mk(0, 1, 0, 0, 32'h13,       32'h80,       0, 0, 32'hDEADBEEF, 32'h0);
        tab[3]  = mk(1, 0, 0, 0, 32'h13,       32'h0,        1, 0, 32'hFFFFFF80, 32'h0);
        tab[4]  = mk(1, 0, 0, 1, 32'h13,       32'h0,        1, 0, 32'h00000080, 32'h0);
        tab[5]  = mk(1, 0, 2, 0, 32'h10,       32'h0,        1, 0, 32'h80ADBEEF, 32'h0);
        tab[6]  = mk(1, 0, 1, 0, 32'h11,       32'h0,        1, 1, 32'h0,        32'h11);
        tab[7]  = mk(0, 1, 2, 0, 32'h12,       32'h11111111, 0, 1, 32'h0,        32'h12);
        tab[8]  = mk(1, 0, 2, 0, 32'h10,       32'h0,        1, 0, 32'h80ADBEEF, 32'h12);
        tab[9]  = mk(1, 0, 2, 0, 32'h1000,     32'h0,        1, 1, 32'h0,        32'h1000);
        tab[10] = mk(0, 1, 2, 0, 32'h1000,     32'h55555555, 0, 1, 32'h0,        32'h1000);
        tab[11] = mk(1, 0, 2, 0, 32'h0,        32'h0,        1, 0, 32'h0BADF00D, 32'h1000);
        tab[12] = mk(1, 1, 1, 0, 32'h10,       32'h1234,     1, 0, SIMUL_EXP,    32'h1000);
        tab[13] = mk(1, 0, 2, 0, 32'h10,       32'h0,        1, 0, 32'h80AD1234, 32'h1000);
        tab[14] = mk(1, 0, 3, 0, 32'h10,       32'h0,        1, 1, 32'h0,        32'h10);
        tab[15] = mk(1, 0, 1, 1, 32'h12,       32'h0,        1, 0, 32'h000080AD, 32'h10);
        tab[16] = mk(0, 1, 1, 0, 32'hFFE,      32'hCAFE,     0, 0, 32'h000080AD, 32'h10);
        tab[17] = mk(1, 0, 1, 0, 32'hFFE,      32'h0,        1, 0, 32'hFFFFCAFE, 32'h10);
        tab[18] = mk(1, 0, 0, 1, 32'hFFF,      32'h0,        1, 0, 32'h000000CA, 32'h10);
        tab[19] = mk(1, 0, 2, 0, 32'hFFFFFFFC, 32'h0,        1, 1, 32'h0,        32'hFFFFFFFC);

        n_vec = 0; n_err = 0; m_hold = 32'h0; m_fa = 32'h0;
        reset = 1'b1; memRead = 1'b0; memWrite = 1'b0; memSize = 2'd0; memUnsigned = 1'b0;
        address = 32'h0; writeData = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        chk("reset", 0, "readValid",   32'(readValid),   32'h0);
        chk("reset", 0, "accessFault", 32'(accessFault), 32'h0);
        chk("reset", 0, "readData",    readData,         32'h0);
        chk("reset", 0, "faultAddr",   faultAddr,        32'h0);
        reset = 1'b0;

        // Give every word the random phase can reach a known value.
        for (int k = 0; k < 68; k++) begin
            int w;
            w = (k < 64) ? k : 956 + k;
            v = mk(0, 1, 2, 0, 32'(w * 4), (32'(w) * 32'h9E3779B1) ^ 32'h0BADF00D, 0, 0, 0, 0);
            predict(v, e);
            step("init", k, e);
        end

        for (int i = 0; i < 20; i++) begin
            predict(tab[i], e);
            step("tab", i, tab[i]);
        end

        // Reset arriving while a load response is on the outputs.
        memRead = 1'b1; memWrite = 1'b0; memSize = 2'd2; memUnsigned = 1'b0; address = 32'h10;
        @(posedge clk);
        #2;
        memRead = 1'b0;
        n_vec++;
        chk("rst", 0, "readValid before reset", 32'(readValid), 32'h1);
        reset = 1'b1;
        #1;
        n_vec++;
        chk("rst", 1, "readValid",   32'(readValid),   32'h0);
        chk("rst", 1, "accessFault", 32'(accessFault), 32'h0);
        chk("rst", 1, "readData",    readData,         32'h0);
        chk("rst", 1, "faultAddr",   faultAddr,        32'h0);
        m_hold = 32'h0;
        m_fa   = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        v = mk(1, 0, 2, 0, 32'h10, 32'h0, 0, 0, 0, 0);
        predict(v, e);
        step("rst", 2, e);
        chk("rst", 2, "reload data", readData, 32'h80AD1234);

        for (int n = 0; n < 400; n++) begin
            v.rd  = 1'($urandom_range(0, 1));
            v.wr  = ($urandom_range(0, 2) == 0);
            v.sz  = 2'($urandom_range(0, 3));
            v.uns = 1'($urandom_range(0, 1));
            v.wd  = $urandom;
            sel   = int'($urandom_range(0, 9));
            if (sel <= 6)      v.addr = $urandom_range(0, 255);
            else if (sel == 7) v.addr = $urandom_range(32'hFF0, 32'hFFF);
            else if (sel == 8) v.addr = $urandom_range(32'h1000, 32'h100F);
            else               v.addr = $urandom;
            predict(v, e);
            step("rand", n, e);
        end

        memRead = 1'b0;
        memWrite = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
